// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the UART core: parity/stop-bit options,
// TX/RX state types and the minimum baud divisor.
package uart_pkg;

    localparam logic [1:0] PAR_NONE      = 2'b00;
    localparam logic [1:0] PAR_ODD       = 2'b01;
    localparam logic [1:0] PAR_EVEN      = 2'b10;
    localparam logic [1:0] PAR_SPACE     = 2'b11;

    localparam logic [1:0] STOP_ONE      = 2'b00;
    localparam logic [1:0] STOP_ONE_HALF = 2'b01;
    localparam logic [1:0] STOP_TWO      = 2'b10;

    localparam int MIN_DIV = 4;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
    } rx_state_t;

    // Characters narrower than 8 bits are zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [1:0] mode, input logic [7:0] data);
        case (mode)
            PAR_ODD:  return ~^data;
            PAR_EVEN: return ^data;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO succeeds when a pop
// happens in the same cycle.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  push_data,
    input  logic          push_valid,
    output logic          full,
    output logic [W-1:0]  pop_data,
    output logic          pop_valid,
    input  logic          pop_ready,
    output logic [AW:0]   level
);

    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign pop_valid = (wr_ptr != rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop    = pop_valid & pop_ready;
    assign do_push   = push_valid & (~full | do_pop);
    assign pop_data  = mem[rd_ptr[AW-1:0]];
    assign level     = wr_ptr - rd_ptr;

    // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_fifo_core.sv
// Full-duplex UART with TX/RX FIFOs, runtime baud divisor, configurable
// character width, parity and stop bits, and per-character error flags.
module uart_fifo_core
    import uart_pkg::*;
#(
    parameter int         DATA_BITS = 8,
    parameter logic [1:0] PARITY    = 2'b00,
    parameter logic [1:0] STOP_BITS = 2'b00,
    parameter int         FIFO_AW   = 4,
    parameter int         DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic                 txd,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overflow,
    output logic                 tx_busy,
    output logic [FIFO_AW:0]     tx_level,
    output logic [FIFO_AW:0]     rx_level
);

    localparam int CW = DIV_W + 1;

    logic [DIV_W-1:0] div_eff;
    assign div_eff = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;

    // ---------------- TX path ----------------
    logic                 tx_full, tx_fifo_valid, tx_pop;
    logic [DATA_BITS-1:0] tx_fifo_data;

    uart_sync_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
        .clk(clk), .rst(rst),
        .push_data(tx_data), .push_valid(tx_valid & tx_ready), .full(tx_full),
        .pop_data(tx_fifo_data), .pop_valid(tx_fifo_valid), .pop_ready(tx_pop),
        .level(tx_level)
    );
    assign tx_ready = ~tx_full;

    tx_state_t            tx_state, tx_state_d;
    logic [CW-1:0]        tx_cnt, tx_cnt_d, stop_len, tx_end;
    logic [DIV_W-1:0]     tx_div, tx_div_d;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_d;
    logic [3:0]           tx_bit, tx_bit_d;
    logic                 tx_par, tx_par_d, txd_d, tx_bit_done;

    always_comb begin
        case (STOP_BITS)
            STOP_ONE_HALF: stop_len = {1'b0, tx_div} + CW'(tx_div >> 1);
            STOP_TWO:      stop_len = {tx_div, 1'b0};
            default:       stop_len = {1'b0, tx_div};
        endcase
    end

    assign tx_end      = (tx_state == TX_STOP) ? stop_len : {1'b0, tx_div};
    assign tx_bit_done = (tx_cnt == tx_end - CW'(1));

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt + CW'(1);
        tx_div_d   = tx_div;
        tx_shift_d = tx_shift;
        tx_par_d   = tx_par;
        tx_bit_d   = tx_bit;
        tx_pop     = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_pop   = tx_fifo_valid;
            end
            TX_START: if (tx_bit_done) begin
                tx_state_d = TX_DATA;
                tx_cnt_d   = '0;
            end
            TX_DATA: if (tx_bit_done) begin
                tx_cnt_d = '0;
                if (tx_bit == 4'(DATA_BITS - 1)) begin
                    tx_state_d = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
                end else begin
                    tx_bit_d   = tx_bit + 4'd1;
                    tx_shift_d = tx_shift >> 1;
                end
            end
            TX_PARITY: if (tx_bit_done) begin
                tx_state_d = TX_STOP;
                tx_cnt_d   = '0;
            end
            TX_STOP: if (tx_bit_done) begin
                tx_state_d = TX_IDLE;
                tx_cnt_d   = '0;
                tx_pop     = tx_fifo_valid;   // chain the next character with no idle gap
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_pop) begin
            tx_state_d = TX_START;
            tx_cnt_d   = '0;
            tx_div_d   = div_eff;
            tx_shift_d = tx_fifo_data;
            tx_par_d   = parity_bit(PARITY, 8'(tx_fifo_data));
            tx_bit_d   = '0;
        end
        case (tx_state_d)
            TX_START:  txd_d = 1'b0;
            TX_DATA:   txd_d = tx_shift_d[0];
            TX_PARITY: txd_d = tx_par_d;
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_div   <= DIV_W'(MIN_DIV);
            tx_shift <= '0;
            tx_bit   <= '0;
            tx_par   <= 1'b0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_div   <= tx_div_d;
            tx_shift <= tx_shift_d;
            tx_bit   <= tx_bit_d;
            tx_par   <= tx_par_d;
            txd      <= txd_d;
        end
    end

    assign tx_busy = (tx_state != TX_IDLE) | tx_fifo_valid;

    // ---------------- RX path ----------------
    logic rx_meta, rx_sync, rx_prev, rx_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end
    assign rx_fall = rx_prev & ~rx_sync;

    rx_state_t            rx_state, rx_state_d;
    logic [DIV_W-1:0]     rx_cnt, rx_cnt_d, rx_div, rx_div_d;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_d;
    logic [3:0]           rx_bit, rx_bit_d;
    logic                 rx_par_err, rx_par_err_d, rx_write, rx_full;
    logic                 rx_half_done, rx_bit_done;
    logic [DATA_BITS+1:0] rx_head;

    assign rx_half_done = (rx_cnt == (rx_div >> 1) - DIV_W'(1));
    assign rx_bit_done  = (rx_cnt == rx_div - DIV_W'(1));

    always_comb begin
        rx_state_d   = rx_state;
        rx_cnt_d     = rx_cnt + DIV_W'(1);
        rx_div_d     = rx_div;
        rx_shift_d   = rx_shift;
        rx_bit_d     = rx_bit;
        rx_par_err_d = rx_par_err;
        rx_write     = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_fall) begin
                    rx_state_d = RX_START;
                    rx_div_d   = div_eff;
                end
            end
            RX_START: if (rx_half_done) begin
                rx_cnt_d     = '0;
                rx_bit_d     = '0;
                rx_par_err_d = 1'b0;
                rx_state_d   = rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_bit_done) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync, rx_shift[DATA_BITS-1:1]};
                if (rx_bit == 4'(DATA_BITS - 1))
                    rx_state_d = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
                else
                    rx_bit_d = rx_bit + 4'd1;
            end
            RX_PARITY: if (rx_bit_done) begin
                rx_cnt_d     = '0;
                rx_par_err_d = rx_sync != parity_bit(PARITY, 8'(rx_shift));
                rx_state_d   = RX_STOP;
            end
            RX_STOP: if (rx_bit_done) begin
                rx_write   = 1'b1;
                rx_state_d = rx_sync ? RX_IDLE : RX_BREAK;
            end
            RX_BREAK: begin
                rx_cnt_d = '0;
                if (rx_sync) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state    <= RX_IDLE;
            rx_cnt      <= '0;
            rx_div      <= DIV_W'(MIN_DIV);
            rx_shift    <= '0;
            rx_bit      <= '0;
            rx_par_err  <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            rx_state    <= rx_state_d;
            rx_cnt      <= rx_cnt_d;
            rx_div      <= rx_div_d;
            rx_shift    <= rx_shift_d;
            rx_bit      <= rx_bit_d;
            rx_par_err  <= rx_par_err_d;
            rx_overflow <= rx_write & rx_full & ~(rx_valid & rx_ready);
        end
    end

    // Entry layout: {parity_err, frame_err, data}; the stop sample itself decides frame_err.
    uart_sync_fifo #(.W(DATA_BITS + 2), .AW(FIFO_AW)) u_rx_fifo (
        .clk(clk), .rst(rst),
        .push_data({rx_par_err, ~rx_sync, rx_shift}), .push_valid(rx_write), .full(rx_full),
        .pop_data(rx_head), .pop_valid(rx_valid), .pop_ready(rx_ready),
        .level(rx_level)
    );

    assign rx_data       = rx_head[DATA_BITS-1:0];
    assign rx_frame_err  = rx_head[DATA_BITS];
    assign rx_parity_err = rx_head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_fifo_core.sv
// Self-checking bench for uart_fifo_core (8 data bits, even parity, one stop bit):
// directed frames plus random loopback traffic against a queue-based reference.
module tb_uart_fifo_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxd, txd;
    logic [15:0] baud_div;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;
    logic        rx_frame_err, rx_parity_err, rx_overflow, tx_busy;
    logic [4:0]  tx_level, rx_level;

    logic        loopback, rxd_drv;
    int          errors = 0;
    int          checks = 0;
    int          ovf_count = 0;
    logic [7:0]  q[$];

    assign rxd = loopback ? txd : rxd_drv;

    always #5 clk = ~clk;

    always @(posedge clk) if (rx_overflow === 1'b1) ovf_count++;

    uart_fifo_core #(
        .DATA_BITS(8), .PARITY(2'b10), .STOP_BITS(2'b00), .FIFO_AW(4), .DIV_W(16)
    ) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .txd(txd), .baud_div(baud_div),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
        .rx_overflow(rx_overflow), .tx_busy(tx_busy),
        .tx_level(tx_level), .rx_level(rx_level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Even parity bit: 1 when the character holds an odd number of ones.
    function automatic logic even_par(input logic [7:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    // Line levels of one frame, index 0 = start bit, index 10 = stop bit.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        return {1'b1, even_par(d), d, 1'b0};
    endfunction

    task automatic send_rx(input logic [7:0] d, input logic bad_par, input logic stop_val,
                           input int div, input logic idle_val);
        logic [10:0] f;
        f     = frame_of(d);
        f[9]  = f[9] ^ bad_par;
        f[10] = stop_val;
        for (int b = 0; b < 11; b++) begin
            rxd_drv = f[b];
            repeat (div) @(negedge clk);
        end
        rxd_drv = idle_val;
    endtask

    task automatic wait_rx_level(input string tag, input int n, input int budget);
        int i;
        i = 0;
        while (rx_level !== 5'(n) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, rx_level, n);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        @(negedge clk);
        check(tag, {rx_valid, rx_parity_err, rx_frame_err, rx_data}, {1'b1, pe, fe, d});
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        logic [10:0] exp_frame, got;
        logic [7:0]  seen, d;
        logic [7:0]  t2_bytes [3];
        int          cur, t, n, budget, ovf_before;

        rst = 1'b1; rxd_drv = 1'b1; loopback = 1'b0; baud_div = 16'd8;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {txd, tx_ready, rx_valid, rx_overflow, tx_busy, tx_level, rx_level},
              {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0});
        rst = 1'b0;
        @(negedge clk);

        // Single character 0xA5, exact line waveform and N+2 start latency.
        tx_data = 8'hA5; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("t1_idle_n1", txd, 1'b1);
        @(negedge clk);
        exp_frame = 11'b1_0_10100101_0;
        for (int b = 0; b < 11; b++) begin
            for (int j = 0; j < 8; j++) begin
                seen[j] = txd;
                @(negedge clk);
            end
            check($sformatf("t1_bit%0d", b), seen, {8{exp_frame[b]}});
        end
        check("t1_done", {tx_busy, txd}, {1'b0, 1'b1});

        // Back-to-back loopback: no idle gap between frames, all received clean.
        loopback = 1'b1;
        repeat (2) @(negedge clk);
        t2_bytes[0] = 8'h00; t2_bytes[1] = 8'hFF; t2_bytes[2] = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            tx_data = t2_bytes[k]; tx_valid = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("t2_tx_level", {tx_busy, tx_level}, {1'b1, 5'd2});
        cur = 1;
        for (int k = 0; k < 3; k++) begin
            got = '0;
            for (int b = 0; b < 11; b++) begin
                t = 88 * k + 8 * b + 4;
                repeat (t - cur) @(negedge clk);
                cur = t;
                got[b] = txd;
            end
            check($sformatf("t2_frame%0d", k), got, frame_of(t2_bytes[k]));
        end
        wait_rx_level("t2_rx_level", 3, 200);
        for (int k = 0; k < 3; k++) pop_check($sformatf("t2_pop%0d", k), t2_bytes[k], 1'b0, 1'b0);

        // Random loopback traffic with random baud divisors (below-minimum included).
        baud_div = 16'($urandom_range(0, 9));
        repeat (2) @(negedge clk);
        n = 10;
        q.delete();
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            tx_data = d; tx_valid = 1'b1;
            q.push_back(d);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("rnd_tx_level", tx_level, n - 1);
        budget = 0;
        while (q.size() > 0 && budget < 4000) begin
            rx_ready = 1'($urandom_range(0, 1));
            if (rx_ready && rx_valid === 1'b1) begin
                check("rnd_rx", {rx_parity_err, rx_frame_err, rx_data}, {2'b00, q[0]});
                void'(q.pop_front());
            end
            @(negedge clk);
            budget++;
        end
        rx_ready = 1'b0;
        check("rnd_drain", q.size(), 0);
        check("rnd_empty", {rx_level, tx_busy}, {5'd0, 1'b0});

        // Frame error followed by a held break: exactly one entry.
        baud_div = 16'd8; loopback = 1'b0; rxd_drv = 1'b1;
        repeat (4) @(negedge clk);
        send_rx(8'h55, 1'b0, 1'b0, 8, 1'b0);
        repeat (60) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (30) @(negedge clk);
        check("t3_level", rx_level, 1);
        pop_check("t3_frame_err", 8'h55, 1'b0, 1'b1);

        // Wrong parity bit flags the entry.
        send_rx(8'hC3, 1'b1, 1'b1, 8, 1'b1);
        wait_rx_level("par_level", 1, 40);
        pop_check("par_err", 8'hC3, 1'b1, 1'b0);

        // 3-cycle glitch is rejected; the following frame arrives intact.
        rxd_drv = 1'b0;
        repeat (3) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (30) @(negedge clk);
        check("t4_glitch", rx_level, 0);
        send_rx(8'h12, 1'b0, 1'b1, 8, 1'b1);
        wait_rx_level("t4_level", 1, 40);
        pop_check("t4_pop", 8'h12, 1'b0, 1'b0);

        // Overflow: 17 characters into a 16-deep FIFO with no pops.
        q.delete();
        ovf_before = ovf_count;
        for (int i = 0; i < 17; i++) begin
            d = 8'($urandom);
            if (i < 16) q.push_back(d);
            send_rx(d, 1'b0, 1'b1, 8, 1'b1);
        end
        repeat (20) @(negedge clk);
        check("t5_level", rx_level, 16);
        check("t5_ovf_pulses", ovf_count - ovf_before, 1);
        for (int i = 0; i < 16; i++) pop_check($sformatf("t5_pop%0d", i), q[i], 1'b0, 1'b0);
        check("t5_empty", rx_level, 0);

        // Reset in the middle of a looped-back frame.
        loopback = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            tx_data = 8'h5A + 8'(k); tx_valid = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("t6_mid_frame", {tx_busy, rx_level}, {1'b1, 5'd0});
        rst = 1'b1;
        @(negedge clk);
        check("t6_reset", {txd, tx_level, rx_level, tx_busy, rx_valid},
              {1'b1, 5'd0, 5'd0, 1'b0, 1'b0});
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("t6_no_spurious", {rx_level, txd, tx_busy}, {5'd0, 1'b1, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
